// File: rtl/rv32i_dmem_pkg.sv
// rtl/rv32i_dmem_pkg.sv - shared encodings and widths for the data-memory responder
package rv32i_dmem_pkg;

    localparam int LANE_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rv32i_dmem_if.sv
// rtl/rv32i_dmem_if.sv - load/store request/ack bus; err exists only with DMEM_RANGE_CHECK_EN
interface rv32i_dmem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wr_mask;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        busy;
`ifdef DMEM_RANGE_CHECK_EN
    logic        err;
`endif

    modport master (
        output req, we, addr, wr_mask, wdata,
`ifdef DMEM_RANGE_CHECK_EN
        input  err,
`endif
        input  ack, rdata, busy
    );

    modport slave (
        input  req, we, addr, wr_mask, wdata,
`ifdef DMEM_RANGE_CHECK_EN
        output err,
`endif
        output ack, rdata, busy
    );
endinterface

// File: rtl/rv32i_dmem_bank.sv
// rtl/rv32i_dmem_bank.sv - DEPTH x 32 single-port array, byte write enables, synchronous read
module rv32i_dmem_bank
    import rv32i_dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [3:0]               be,
    input  logic [31:0]              wdata,
    output logic [31:0]              q
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                mem[addr][k*LANE_W +: LANE_W] <= wdata[k*LANE_W +: LANE_W];
            end
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/rv32i_dmem_responder.sv
// rtl/rv32i_dmem_responder.sv - single-outstanding data-memory responder with wait states
// Optional range checking and err output: DMEM_RANGE_CHECK_EN.
module rv32i_dmem_responder
    import rv32i_dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    rv32i_dmem_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               we_q;
    logic [AW+1:0]      addr_q;
    logic [3:0]         mask_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic [31:0]        bank_q;
    logic [AW-1:0]      bank_idx;
    logic [3:0]         bank_be;
    logic [31:0]        rd_shift;
    logic               commit;
    logic               range_bad;

`ifdef DMEM_RANGE_CHECK_EN
    logic               oor_q;
    logic               err_q;
    assign range_bad = oor_q;
`else
    assign range_bad = 1'b0;
`endif

    assign commit = (state == ACCESS) && (cnt == '0);

    // The bank is addressed from the live bus in IDLE so its registered read
    // is already valid when a zero-wait ACCESS commits on the next edge.
    assign bank_idx = (state == IDLE) ? bus.addr[AW+1:2] : addr_q[AW+1:2];
    assign bank_be  = (commit && we_q && !range_bad) ? mask_q : 4'b0000;
    assign rd_shift = bank_q >> {addr_q[1:0], 3'b000};

    rv32i_dmem_bank #(.DEPTH(DEPTH)) u_bank (
        .clk   (clk),
        .addr  (bank_idx),
        .be    (bank_be),
        .wdata (wdata_q),
        .q     (bank_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req) state_nxt = ACCESS;
            ACCESS:  if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ack   = (state == RESP);
        bus.busy  = (state != IDLE);
        bus.rdata = rdata_q;
`ifdef DMEM_RANGE_CHECK_EN
        bus.err   = (state == RESP) && err_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DMEM_RANGE_CHECK_EN
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            if (state == IDLE && bus.req) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr[AW+1:0];
                mask_q  <= bus.wr_mask;
                wdata_q <= bus.wdata;
                cnt     <= WAIT_STATES[CNT_W-1:0];
`ifdef DMEM_RANGE_CHECK_EN
                oor_q   <= |bus.addr[31:AW+2];
`endif
            end else if (state == ACCESS) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    if (!we_q && !range_bad) rdata_q <= rd_shift;
`ifdef DMEM_RANGE_CHECK_EN
                    err_q <= oor_q;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// tb/tb_rv32i_dmem_responder.sv - directed self-checking bench for rv32i_dmem_responder
module tb_rv32i_dmem_responder;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rv32i_dmem_if b0 ();
    rv32i_dmem_if b1 ();

    rv32i_dmem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u0 (
        .clk (clk), .rst_n (rst_n), .bus (b0.slave)
    );
    rv32i_dmem_responder #(.DEPTH(1024), .WAIT_STATES(3)) u1 (
        .clk (clk), .rst_n (rst_n), .bus (b1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Zero-wait port: returns edges from sampling to ack, read data and err at ack.
    task automatic x0(input logic w, input logic [31:0] a, input logic [3:0] m,
                      input logic [31:0] d, output int lat, output logic [31:0] rd,
                      output logic e);
        @(negedge clk);
        b0.req = 1'b1; b0.we = w; b0.addr = a; b0.wr_mask = m; b0.wdata = d;
        @(posedge clk);
        lat = -1; rd = 'x; e = 1'b0;
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            if (b0.ack === 1'b1) begin
                lat = n;
                rd  = b0.rdata;
`ifdef DMEM_RANGE_CHECK_EN
                e   = b0.err;
`endif
                break;
            end
        end
        b0.req = 1'b0;
        @(negedge clk);
        chk("ack_single_cycle", {31'd0, b0.ack}, 32'd0);
    endtask

    // Wait-state port: alt replaces addr one cycle into ACCESS; counts busy cycles.
    task automatic x1(input logic w, input logic [31:0] a, input logic [3:0] m,
                      input logic [31:0] d, input logic [31:0] alt,
                      output int lat, output logic [31:0] rd, output int nbusy);
        @(negedge clk);
        b1.req = 1'b1; b1.we = w; b1.addr = a; b1.wr_mask = m; b1.wdata = d;
        @(posedge clk);
        lat = -1; rd = 'x; nbusy = 0;
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            if (b1.busy === 1'b1) nbusy++;
            if (n == 1) begin
                b1.addr = alt; b1.wdata = ~d;
            end
            if (b1.ack === 1'b1) begin
                lat = n;
                rd  = b1.rdata;
                break;
            end
        end
        b1.req = 1'b0;
        @(negedge clk);
        if (b1.busy === 1'b1) nbusy++;
    endtask

    int          lat;
    int          nb;
    logic [31:0] rd;
    logic        e;

    initial begin
        rst_n = 1'b0;
        b0.req = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wr_mask = '0; b0.wdata = '0;
        b1.req = 1'b0; b1.we = 1'b0; b1.addr = '0; b1.wr_mask = '0; b1.wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: reset state
        chk("reset_ack",   {31'd0, b0.ack},  32'd0);
        chk("reset_busy",  {31'd0, b0.busy}, 32'd0);
        chk("reset_rdata", b0.rdata,         32'd0);

        // 1: reset mid-ACCESS drops a pending store
        x1(1'b1, 32'h40, 4'b1111, 32'hCAFEF00D, 32'h40, lat, rd, nb);
        @(negedge clk);
        b1.req = 1'b1; b1.we = 1'b1; b1.addr = 32'h40; b1.wr_mask = 4'b1111; b1.wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy_before_rst", {31'd0, b1.busy}, 32'd1);
        rst_n = 1'b0;
        b1.req = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, b1.busy}, 32'd0);
        chk("rst_ack",  {31'd0, b1.ack},  32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_ack_after_rst", {31'd0, b1.ack}, 32'd0);
        end
        x1(1'b0, 32'h40, 4'b0000, 32'h0, 32'h40, lat, rd, nb);
        chk("rst_store_dropped", rd, 32'hCAFEF00D);

        // 2: full word store then load, zero wait states
        x0(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, lat, rd, e);
        chk("store_latency", lat, 32'd1);
        x0(1'b0, 32'h10, 4'b0000, 32'h0, lat, rd, e);
        chk("load_latency", lat, 32'd1);
        chk("load_0x10", rd, 32'hDEADBEEF);

        // 3: upper halfword store, rdata holds across stores
        x0(1'b1, 32'h12, 4'b1100, 32'h12340000, lat, rd, e);
        chk("rdata_hold_store", b0.rdata, 32'hDEADBEEF);
        x0(1'b0, 32'h10, 4'b0000, 32'h0, lat, rd, e);
        chk("word_after_half", rd, 32'h1234BEEF);
        x0(1'b0, 32'h13, 4'b0000, 32'h0, lat, rd, e);
        chk("load_0x13", rd, 32'h00000012);
        x0(1'b0, 32'h12, 4'b0000, 32'h0, lat, rd, e);
        chk("load_0x12", rd, 32'h00001234);

        // 4: byte store in lane 1
        x0(1'b1, 32'h11, 4'b0010, 32'h0000AA00, lat, rd, e);
        x0(1'b0, 32'h11, 4'b0000, 32'h0, lat, rd, e);
        chk("load_0x11", rd, 32'h001234AA);

        // wr_mask=0 store is a no-op
        x0(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, lat, rd, e);
        x0(1'b0, 32'h10, 4'b0000, 32'h0, lat, rd, e);
        chk("nomask_store", rd, 32'h1234AAEF);

        // 5: three wait states, busy length, addr change during ACCESS ignored
        x1(1'b1, 32'h20, 4'b1111, 32'h11223344, 32'h24, lat, rd, nb);
        chk("ws3_store_latency", lat, 32'd4);
        chk("ws3_store_busy", nb, 32'd5);
        x1(1'b0, 32'h20, 4'b0000, 32'h0, 32'h40, lat, rd, nb);
        chk("ws3_load_latency", lat, 32'd4);
        chk("ws3_load_busy", nb, 32'd5);
        chk("ws3_load_data", rd, 32'h11223344);
        x1(1'b0, 32'h24, 4'b0000, 32'h0, 32'h24, lat, rd, nb);
        chk("ws3_addr_change_ignored", rd, 32'hEEDDCCBB === rd ? 32'hDEAD0000 : rd);

`ifdef DMEM_RANGE_CHECK_EN
        // 6: out-of-range store flagged and suppressed
        x0(1'b1, 32'h0, 4'b1111, 32'h55AA55AA, lat, rd, e);
        chk("inrange_store_err", {31'd0, e}, 32'd0);
        x0(1'b1, 32'h1000, 4'b1111, 32'h0BADF00D, lat, rd, e);
        chk("oor_store_err", {31'd0, e}, 32'd1);
        x0(1'b0, 32'h0, 4'b0000, 32'h0, lat, rd, e);
        chk("mem0_unchanged", rd, 32'h55AA55AA);
        x0(1'b0, 32'h1004, 4'b0000, 32'h0, lat, rd, e);
        chk("oor_load_err", {31'd0, e}, 32'd1);
        chk("oor_load_rdata_hold", rd, 32'h55AA55AA);
        x0(1'b0, 32'h0FFC, 4'b0000, 32'h0, lat, rd, e);
        chk("top_word_err", {31'd0, e}, 32'd0);
`else
        // Address bits above the index wrap
        x0(1'b0, 32'h1011, 4'b0000, 32'h0, lat, rd, e);
        chk("wrap_load", rd, 32'h001234AA);
        x0(1'b1, 32'h2010, 4'b0001, 32'h00000077, lat, rd, e);
        x0(1'b0, 32'h10, 4'b0000, 32'h0, lat, rd, e);
        chk("wrap_store", rd, 32'h1234AA77);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32i_dmem_responder.md
Name: rv32i_dmem_responder

Overview:
Memory-side responder for the core's load/store path. It accepts one data-memory request at a time: address, byte write mask and lane-aligned store data. Writes commit only the masked byte lanes. Reads return data shifted down so the addressed byte or halfword sits at bit 0, ready for the core's sign/zero extension. A programmable number of wait states models slow memory behind a request/ack handshake.

Parameters:
DEPTH, 1024, number of 32-bit words; must be a power of 2; index = addr[2+log2(DEPTH)-1:2]
WAIT_STATES, 0, extra cycles spent in ACCESS before the response (0..15)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
req  input  1  request strobe; held high by the requester until ack
we  input  1  1 = store, 0 = load
addr  input  32  byte address
wr_mask  input  4  byte-lane enables {b3,b2,b1,b0}; already shifted to the lane
wdata  input  32  store data; already aligned to wr_mask
ack  output  1  one-cycle response strobe
rdata  output  32  load data; addressed byte at [7:0]
busy  output  1  high whenever state != IDLE
err  output  1  present only with DMEM_RANGE_CHECK_EN

Behaviour:
- States: IDLE, ACCESS, RESP. Encoding is 2 bits. A cnt register (4 bits) holds the remaining wait states.
- Reset (asynchronous, rst_n=0):
  - state=IDLE, cnt=0, ack=0, rdata=0, err=0.
  - Latched request registers are cleared to 0.
  - The memory array is not cleared.
- IDLE with req=1 at edge E0:
  - Latch we, addr, wr_mask and wdata.
  - cnt <= WAIT_STATES; state <= ACCESS.
- ACCESS with cnt != 0: cnt decrements; there is no side effect.
- ACCESS with cnt == 0, at that edge:
  - Store: mem[idx] byte k <= wdata byte k, for each k with wr_mask[k]=1. Other lanes are unchanged. wr_mask=0 is a legal no-op store.
  - Load: rdata <= mem[idx] >> (addr[1:0]*8), zero-filled from the top.
  - state <= RESP.
- RESP: ack=1 for exactly this cycle. Next edge: state <= IDLE.
- ack and rdata are registered; no combinational path runs from req to ack.
- Latency: ack is high during the cycle after edge E(1+WAIT_STATES). Back-to-back throughput is one request per WAIT_STATES+3 cycles.
- Inputs are only sampled in IDLE. Changes to req, addr or data during ACCESS/RESP are ignored.
- A requester that drops req during ACK and raises it again is sampled on the following IDLE edge.
- rdata holds its last load value across stores and idle cycles.
- Reads and writes to the same word in consecutive requests are ordered. The later read sees the earlier write, because only one request is ever outstanding.
- Misaligned halfword/word accesses are not checked. Data is shifted by addr[1:0] regardless, and the upper bytes are zero.
- Address bits above the index are ignored: the memory wraps modulo DEPTH*4.
- Reset mid-operation: return to IDLE and drop the pending request. A store not yet committed (still in ACCESS) never writes. ack does not pulse.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined:
  - The err port exists.
  - A request with addr >= DEPTH*4 performs no write and leaves rdata unchanged.
  - It still completes through ACCESS/RESP. err=1 together with ack in the RESP cycle; err=0 otherwise.
- Undefined: the err port is absent, and addresses wrap as described above.

Decomposition:
- Shared package rv32i_dmem_pkg holds:
  - state encodings IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - lane width constant 8;
  - the wait-count width constant.
- One natural sub-module: rv32i_dmem_bank, a DEPTH x 32 single-port array with 4 byte-write enables and a synchronous read.
- The FSM, latches and read shifter stay in the top level.

Test Plan:
1. Reset, then idle → ack=0, rdata=0, busy=0. Assert rst_n low mid-ACCESS with a store pending → word unchanged, no ack.
2. WAIT_STATES=0. Store addr=0x10, wr_mask=4'b1111, wdata=0xDEADBEEF, then load addr=0x10 → ack 1 cycle after sampling each; rdata=0xDEADBEEF.
3. Store addr=0x12, wr_mask=4'b1100, wdata=0x12340000 → word 0x1234BEEF. Load addr=0x13 → rdata=0x00000012. Load addr=0x12 → 0x00001234.
4. Byte store addr=0x11, wr_mask=4'b0010, wdata=0x0000AA00 → word 0x1234AAEF. Load addr=0x11 → rdata=0x001234AA.
5. WAIT_STATES=3 → ack appears exactly 4 cycles after the req sampling edge. busy high for 5 cycles. Changing addr during ACCESS has no effect.
6. DMEM_RANGE_CHECK_EN, DEPTH=1024. Store to addr=0x1000 → err=1 with ack, and mem[0] unchanged. Load addr=0x0FFC → err=0.
